// File: rtl/mem_req_initiator.sv
// Processor-side initiator for the tagged memory model: issues load/store commands with retry
// and tracks outstanding load tags in order. Define MEM_REQ_TIMEOUT_EN for the head-of-queue timeout.
module mem_req_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    output logic                   resp_valid,
    output logic [31:0]            resp_data,
    output logic                   resp_err,
    output logic [1:0]             proc2mem_command,
    output logic [31:0]            proc2mem_addr,
    output logic [31:0]            proc2mem_data,
    input  logic [3:0]             mem2proc_response,
    input  logic [31:0]            mem2proc_data,
    input  logic [3:0]             mem2proc_tag,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   tag_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [1:0]    CMD_NONE  = 2'd0;
    localparam logic [1:0]    CMD_LOAD  = 2'd1;
    localparam logic [1:0]    CMD_STORE = 2'd2;

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t        state_r, state_s;
    logic          req_ready_s, accept_s, push_s, match_s, tmo_pop_s, pop_s, full_s, empty_s;
    logic [1:0]    cmd_r;
    logic [31:0]   addr_r, data_r;
    logic [3:0]    tag_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          resp_valid_r, resp_err_r, tag_err_r;
    logic [31:0]   resp_data_r;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);
    // Only the head is compared, so a tag pushed this cycle can never match this cycle.
    assign match_s = (mem2proc_tag != 4'd0) && !empty_s && (mem2proc_tag == tag_mem_r[rd_ptr_r]);
    assign pop_s   = match_s || tmo_pop_s;

    // Next-state, handshake and push decode
    always_comb begin
        state_s     = state_r;
        req_ready_s = 1'b0;
        accept_s    = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = !full_s || req_is_store;
                if (req_valid && req_ready_s) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                if (mem2proc_response != 4'd0) begin
                    state_s = IDLE;
                    push_s  = (cmd_r == CMD_LOAD);
                end else begin
                    state_s = ISSUE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Issue register; drives memory directly and holds steady while retrying
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r  <= CMD_NONE;
            addr_r <= 32'd0;
            data_r <= 32'd0;
        end else if (accept_s) begin
            cmd_r  <= req_is_store ? CMD_STORE : CMD_LOAD;
            addr_r <= req_addr;
            data_r <= req_data;
        end else if ((state_r == ISSUE) && (mem2proc_response != 4'd0)) begin
            cmd_r  <= CMD_NONE;
        end
    end

    // Outstanding-load tag FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) tag_mem_r[i] <= 4'd0;
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= mem2proc_response;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Response pulse and sticky unexpected-tag flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'd0;
            resp_err_r   <= 1'b0;
            tag_err_r    <= 1'b0;
        end else begin
            resp_valid_r <= pop_s;
            resp_data_r  <= match_s ? mem2proc_data : 32'd0;
            resp_err_r   <= tmo_pop_s;
            tag_err_r    <= tag_err_r | ((mem2proc_tag != 4'd0) && !match_s);
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(TIMEOUT);
    logic [TW-1:0] wait_r;

    // Cycles the current head has waited; restarts for each new head
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   wait_r <= {TW{1'b0}};
        else if (pop_s || empty_s) wait_r <= {TW{1'b0}};
        else                       wait_r <= wait_r + {{(TW-1){1'b0}}, 1'b1};
    end

    // A matching tag in the timeout cycle takes priority over the forced pop
    assign tmo_pop_s = !empty_s && (wait_r == TMO_VAL) && !match_s;
`else
    // TIMEOUT is a non-negative count, so this is inert without the timeout feature
    assign tmo_pop_s = (TIMEOUT < 0);
`endif

    assign req_ready        = req_ready_s & ~rst;
    assign proc2mem_command = cmd_r;
    assign proc2mem_addr    = addr_r;
    assign proc2mem_data    = data_r;
    assign resp_valid       = resp_valid_r;
    assign resp_data        = resp_data_r;
    assign resp_err         = resp_err_r;
    assign outstanding      = count_r;
    assign tag_err          = tag_err_r;
endmodule

// File: tb/tb_mem_req_initiator.sv
// Self-checking bench for mem_req_initiator: directed scenarios plus randomized traffic against
// a queue-based reference model (timeout behaviour modelled when MEM_REQ_TIMEOUT_EN is defined).
module tb_mem_req_initiator;
    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_is_store = 1'b0;
    logic [31:0] req_addr = 32'd0, req_data = 32'd0;
    logic        req_ready, resp_valid, resp_err, tag_err;
    logic [31:0] resp_data, proc2mem_addr, proc2mem_data;
    logic [1:0]  proc2mem_command;
    logic [3:0]  mem2proc_response = 4'd0, mem2proc_tag = 4'd0;
    logic [31:0] mem2proc_data = 32'd0;
    logic [2:0]  outstanding;

    mem_req_initiator #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .outstanding(outstanding), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;

    // Reference model: one pending memory request plus an in-order queue of load tags
    logic [3:0]  tq[$];
    bit          m_busy, m_store, m_err, exp_rv, exp_re;
    logic [31:0] m_addr, m_data, exp_rd;
    int          m_age;

    task automatic model_reset();
        tq.delete();
        m_busy = 0; m_store = 0; m_err = 0; exp_rv = 0; exp_re = 0; exp_rd = 32'd0; m_age = 0;
    endtask

    function automatic logic [1:0] exp_cmd();
        return m_busy ? (m_store ? 2'd2 : 2'd1) : 2'd0;
    endfunction

    // Apply the current inputs to the model, then advance one clock and settle
    task automatic step();
        int sz0;
        bit acc;
        sz0 = tq.size();
        exp_rv = 0; exp_re = 0; exp_rd = 32'd0;
        acc = !m_busy && req_valid && (sz0 < DEPTH || req_is_store);
        if (mem2proc_tag != 4'd0) begin
            if (sz0 > 0 && tq[0] == mem2proc_tag) begin
                void'(tq.pop_front());
                exp_rv = 1; exp_rd = mem2proc_data; m_age = 0;
            end else begin
                m_err = 1;
            end
        end
`ifdef MEM_REQ_TIMEOUT_EN
        if (!exp_rv) begin
            if (sz0 > 0 && m_age == TMO) begin
                void'(tq.pop_front());
                exp_rv = 1; exp_re = 1; m_age = 0;
            end else if (sz0 > 0) begin
                m_age++;
            end else begin
                m_age = 0;
            end
        end
`endif
        if (m_busy && mem2proc_response != 4'd0) begin
            m_busy = 0;
            if (!m_store) tq.push_back(mem2proc_response);
        end else if (acc) begin
            m_busy = 1; m_store = req_is_store; m_addr = req_addr; m_data = req_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_issue(input logic [3:0] t);
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = $urandom;
        step();
        req_valid = 1'b0; mem2proc_response = t;
        step();
        mem2proc_response = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tot++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", req_ready); end
        tot++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 32'd0 || proc2mem_data !== 32'd0) begin
            bad++; $display("FAIL reset_mem got=%0d/%h/%h exp=0/0/0", proc2mem_command, proc2mem_addr, proc2mem_data); end
        tot++; if (outstanding !== 3'd0 || tag_err !== 1'b0) begin
            bad++; $display("FAIL reset_state got out=%0d err=%0b exp=0/0", outstanding, tag_err); end
        tot++; if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_resp got=%0b/%h/%0b exp=0/0/0", resp_valid, resp_data, resp_err); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_load();
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h100; #1;
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b exp=1", req_ready); end
        step();
        req_valid = 1'b0; mem2proc_response = 4'd3;
        tot++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin
            bad++; $display("FAIL single_cmd got=%0d/%h exp=1/100", proc2mem_command, proc2mem_addr); end
        step();
        mem2proc_response = 4'd0;
        tot++; if (outstanding !== 3'd1 || proc2mem_command !== 2'd0) begin
            bad++; $display("FAIL single_push got out=%0d cmd=%0d exp=1/0", outstanding, proc2mem_command); end
        repeat (3) step();
        mem2proc_tag = 4'd3; mem2proc_data = 32'hDEADBEEF;
        step();
        mem2proc_tag = 4'd0;
        tot++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_err !== 1'b0) begin
            bad++; $display("FAIL single_resp got=%0b/%h/%0b exp=1/deadbeef/0", resp_valid, resp_data, resp_err); end
        tot++; if (outstanding !== 3'd0 || tag_err !== 1'b0) begin
            bad++; $display("FAIL single_pop got out=%0d err=%0b exp=0/0", outstanding, tag_err); end
        step();
        tot++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b exp=0", resp_valid); end
    endtask

    task automatic test_retry();
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h40; req_data = 32'h12345678;
        step();
        req_valid = 1'b0; req_is_store = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = (i == 3) ? 4'd5 : 4'd0;
            tot++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h40 || proc2mem_data !== 32'h12345678) begin
                bad++; $display("FAIL retry_hold[%0d] got=%0d/%h/%h exp=2/40/12345678", i, proc2mem_command, proc2mem_addr, proc2mem_data); end
            step();
        end
        mem2proc_response = 4'd0;
        tot++; if (proc2mem_command !== 2'd0 || outstanding !== 3'd0 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL retry_done got cmd=%0d out=%0d rv=%0b exp=0/0/0", proc2mem_command, outstanding, resp_valid); end
    endtask

    task automatic test_full();
        logic [31:0] d;
        for (int t = 1; t <= 4; t++) load_issue(4'(t));
        tot++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", outstanding); end
        req_valid = 1'b1; req_is_store = 1'b0; #1;
        tot++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_holdoff got=%0b exp=0", req_ready); end
        step();
        tot++; if (proc2mem_command !== 2'd0) begin bad++; $display("FAIL full_noissue got=%0d exp=0", proc2mem_command); end
        req_is_store = 1'b1; #1;
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_store_ready got=%0b exp=1", req_ready); end
        step();
        req_valid = 1'b0; req_is_store = 1'b0; mem2proc_response = 4'd7;
        tot++; if (proc2mem_command !== 2'd2) begin bad++; $display("FAIL full_store_cmd got=%0d exp=2", proc2mem_command); end
        step();
        mem2proc_response = 4'd0;
        tot++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_store_nopush got=%0d exp=4", outstanding); end
        d = $urandom;
        req_valid = 1'b1; mem2proc_tag = 4'd1; mem2proc_data = d;
        step();
        mem2proc_tag = 4'd0;
        tot++; if (resp_valid !== 1'b1 || resp_data !== d) begin
            bad++; $display("FAIL full_pop got=%0b/%h exp=1/%h", resp_valid, resp_data, d); end
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%0b exp=1", req_ready); end
        step();
        req_valid = 1'b0; mem2proc_response = 4'd5;
        tot++; if (proc2mem_command !== 2'd1) begin bad++; $display("FAIL full_fifth got=%0d exp=1", proc2mem_command); end
        step();
        mem2proc_response = 4'd0;
        for (int t = 2; t <= 5; t++) begin
            d = $urandom; mem2proc_tag = 4'(t); mem2proc_data = d;
            step();
            tot++; if (resp_valid !== 1'b1 || resp_data !== d) begin
                bad++; $display("FAIL full_drain[%0d] got=%0b/%h exp=1/%h", t, resp_valid, resp_data, d); end
        end
        mem2proc_tag = 4'd0;
        tot++; if (outstanding !== 3'd0 || tag_err !== 1'b0) begin
            bad++; $display("FAIL full_empty got out=%0d err=%0b exp=0/0", outstanding, tag_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        load_issue(4'd6);
        load_issue(4'd7);
        req_valid = 1'b1; req_is_store = 1'b0;
        step();
        d = $urandom;
        req_valid = 1'b0; mem2proc_response = 4'd8; mem2proc_tag = 4'd6; mem2proc_data = d;
        step();
        mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
        tot++; if (outstanding !== 3'd2) begin bad++; $display("FAIL pushpop_count got=%0d exp=2", outstanding); end
        tot++; if (resp_valid !== 1'b1 || resp_data !== d) begin
            bad++; $display("FAIL pushpop_data got=%0b/%h exp=1/%h", resp_valid, resp_data, d); end
        for (int t = 7; t <= 8; t++) begin mem2proc_tag = 4'(t); step(); end
        mem2proc_tag = 4'd0;
        tot++; if (outstanding !== 3'd0 || tag_err !== 1'b0) begin
            bad++; $display("FAIL pushpop_drain got out=%0d err=%0b exp=0/0", outstanding, tag_err); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req_valid = 1'($urandom); req_is_store = 1'($urandom); req_addr = $urandom; req_data = $urandom;
            mem2proc_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mem2proc_tag = (tq.size() > 0 && $urandom_range(0, 2) == 0) ? tq[0] : 4'd0;
            mem2proc_data = $urandom;
            #1;
            tot++; if (req_ready !== (!m_busy && (tq.size() < DEPTH || req_is_store))) begin
                bad++; $display("FAIL rand_ready[%0d] got=%0b", c, req_ready); end
            step();
            tot++; if (proc2mem_command !== exp_cmd()) begin
                bad++; $display("FAIL rand_cmd[%0d] got=%0d exp=%0d", c, proc2mem_command, exp_cmd()); end
            if (m_busy) begin
                tot++; if (proc2mem_addr !== m_addr || proc2mem_data !== m_data) begin
                    bad++; $display("FAIL rand_addr[%0d] got=%h/%h exp=%h/%h", c, proc2mem_addr, proc2mem_data, m_addr, m_data); end
            end
            tot++; if (outstanding !== 3'(tq.size())) begin
                bad++; $display("FAIL rand_out[%0d] got=%0d exp=%0d", c, outstanding, tq.size()); end
            tot++; if (resp_valid !== exp_rv || resp_err !== exp_re || (exp_rv && resp_data !== exp_rd)) begin
                bad++; $display("FAIL rand_resp[%0d] got=%0b/%0b/%h exp=%0b/%0b/%h", c, resp_valid, resp_err, resp_data, exp_rv, exp_re, exp_rd); end
            tot++; if (tag_err !== m_err) begin bad++; $display("FAIL rand_tagerr[%0d] got=%0b exp=%0b", c, tag_err, m_err); end
        end
        req_valid = 1'b0; mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    endtask

    task automatic test_error_reset();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; model_reset();
        load_issue(4'd6);
        load_issue(4'd7);
        mem2proc_tag = 4'd9;
        step();
        mem2proc_tag = 4'd0;
        tot++; if (tag_err !== 1'b1 || outstanding !== 3'd2 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL err_mismatch got err=%0b out=%0d rv=%0b exp=1/2/0", tag_err, outstanding, resp_valid); end
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h200;
        step();
        req_valid = 1'b0;
        tot++; if (proc2mem_command !== 2'd1) begin bad++; $display("FAIL err_issue got=%0d exp=1", proc2mem_command); end
        rst = 1'b1; #1;
        tot++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 32'd0 || outstanding !== 3'd0 || tag_err !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL err_async_rst got cmd=%0d addr=%h out=%0d err=%0b rdy=%0b exp=0", proc2mem_command, proc2mem_addr, outstanding, tag_err, req_ready); end
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        mem2proc_tag = 4'd6;
        step();
        mem2proc_tag = 4'd0;
        tot++; if (tag_err !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL err_late_tag got err=%0b rv=%0b exp=1/0", tag_err, resp_valid); end
    endtask

`ifdef MEM_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        load_issue(4'd2);
        k = 0;
        while (resp_valid !== 1'b1 && k < 40) begin step(); k++; end
        tot++; if (k !== TMO + 1) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", k, TMO + 1); end
        tot++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'd0 || outstanding !== 3'd0) begin
            bad++; $display("FAIL tmo_resp got rv=%0b re=%0b d=%h out=%0d exp=1/1/0/0", resp_valid, resp_err, resp_data, outstanding); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_load();
        test_retry();
        test_full();
        test_back_to_back();
        test_random();
        test_error_reset();
`ifdef MEM_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Processor-side initiator for the tagged unified memory model used for instruction and data memory.
- Accepts load/store requests from the pipeline over a valid/ready handshake and drives command, address and data to memory.
- Retries each request until memory returns a nonzero response tag.
- Tracks outstanding load tags in order and returns load data to the pipeline when the matching mem2proc_tag arrives.

Parameters:
- DEPTH, 4, maximum outstanding loads; power of 2, range 2..8.
- TIMEOUT, 255, cycles the oldest load may wait before a timeout error; only used with MEM_REQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  initiator can accept a request this cycle
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_data  in  32  store data
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_data  out  32  load data
- resp_err  out  1  qualifies resp_valid; data invalid (timeout)
- proc2mem_command  out  2  0 = NONE, 1 = LOAD, 2 = STORE
- proc2mem_addr  out  32  memory address
- proc2mem_data  out  32  memory write data
- mem2proc_response  in  4  nonzero = accepted, value is the transaction tag
- mem2proc_data  in  32  returned load data
- mem2proc_tag  in  4  nonzero = data for that tag is on mem2proc_data
- outstanding  out  $clog2(DEPTH)+1  number of loads awaiting data
- tag_err  out  1  sticky unexpected-tag flag

Behaviour:
- Reset values: req_ready 0, resp_valid 0, resp_data 0, resp_err 0, command 0, addr 0, data 0, outstanding 0, tag_err 0, FSM IDLE, FIFO empty.
- FSM state IDLE:
  - req_ready = 1 when the FIFO is not full, or when a store is requested.
  - On req_valid && req_ready, capture is_store, addr and data into the issue register and go to ISSUE.
  - A load presented while the FIFO is full is held off (req_ready = 0).
- FSM state ISSUE:
  - req_ready = 0.
  - proc2mem_command/addr/data are driven from the issue register (registered outputs; command is 1 or 2).
  - If mem2proc_response == 0: stay in ISSUE and re-present the identical command next cycle, indefinitely.
  - If mem2proc_response != 0 and the request is a load: push the response tag into the tag FIFO, command becomes 0 next cycle, go to IDLE.
  - If mem2proc_response != 0 and the request is a store: nothing is pushed, go to IDLE.
- Throughput: at most one request every 2 cycles (IDLE then ISSUE). Command is 0 in every cycle outside ISSUE.
- Completion (checked every cycle, independent of FSM state):
  - If mem2proc_tag != 0, the FIFO is non-empty and mem2proc_tag equals the head tag: pop the head; next cycle resp_valid = 1, resp_data = mem2proc_data as sampled, resp_err = 0.
  - Completion is strictly in order, compared against the head only.
  - If mem2proc_tag != 0 and the FIFO is empty, or the tag mismatches the head: set tag_err (sticky until rst), no pop, no resp_valid.
  - mem2proc_tag == 0 is ignored.
- Simultaneous push and pop in one cycle: both take effect, outstanding is unchanged. A tag pushed this cycle is never matched this cycle.
- outstanding = push count minus pop count; never exceeds DEPTH. Read and write pointers wrap modulo DEPTH.
- Stores do not wait for outstanding loads. Memory ordering is the memory model's responsibility.
- rst asserted mid-operation: immediately clears the FSM, FIFO, outputs and tag_err. A late tag arriving after reset is flagged as tag_err.

Optional Feature:
- Macro: MEM_REQ_TIMEOUT_EN.
- Defined:
  - A counter tracks cycles the current FIFO head has waited, cleared on every pop and while the FIFO is empty.
  - When the counter reaches TIMEOUT, the head is force-popped; next cycle resp_valid = 1 and resp_err = 1, with resp_data = 0.
  - If a matching tag arrives in the same cycle as the timeout, the normal completion wins.
- Not defined: no counter exists, resp_err is tied to 0, and the FIFO may wait forever.

Test Plan:
- Single load: load addr 0x100; mem response 3 on the first ISSUE cycle; tag 3 with data 0xDEADBEEF four cycles later -> one resp_valid pulse with resp_data 0xDEADBEEF, outstanding goes 0->1->0, tag_err 0.
- Retry: store addr 0x40 data 0x12345678; response 0 for 3 cycles, then 5 -> command = 2 held with identical addr/data for 4 cycles, then 0; outstanding stays 0; no resp_valid.
- Full FIFO: 4 loads accepted with tags 1,2,3,4 and no data returned -> req_ready 0 for a 5th load, outstanding = 4; a store is still accepted; returning tag 1 -> the 5th load is accepted.
- In-order completion with push and pop in the same cycle: tags 6 and 7 outstanding; a new load gets response 8 in the same cycle tag 6 returns -> outstanding stays 2, resp_data is tag 6's data.
- Error and reset: tag 9 returned while the head is 6 -> tag_err 1, no pop; rst asserted mid-ISSUE -> all outputs 0 asynchronously, tag_err cleared.
- MEM_REQ_TIMEOUT_EN with TIMEOUT = 10: load accepted with tag 2, no data returned -> resp_valid with resp_err 1 exactly 11 cycles after the push, outstanding goes to 0.
